// File: rtl/packet_dispatcher.sv
// rtl/packet_dispatcher.sv - round-robin packet dispatcher into per-core packet buffers
module packet_dispatcher #(
  parameter int NUM_BUF   = 4,
  parameter int MAX_WORDS = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [63:0]        src_data,
  input  logic [23:0]        src_route,
  input  logic               src_bop,
  input  logic               src_eop,
  input  logic               src_wr,
  output logic               src_rdy,
  output logic [63:0]        buf_data,
  output logic [23:0]        buf_pkt_route,
  output logic [NUM_BUF-1:0] buf_wr,
  output logic [NUM_BUF-1:0] buf_req,
  input  logic [NUM_BUF-1:0] buf_ack,
  input  logic [NUM_BUF-1:0] buf_empty,
  output logic [31:0]        pkt_count,
  output logic [15:0]        trunc_count,
  output logic [15:0]        err_count
);

  localparam int IW = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_FLUSH, S_RELEASE} state_t;

  state_t               state;
  logic [IW-1:0]        sel;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        pick;
  logic [IW:0]          cand;
  logic                 any_empty;
  logic [7:0]           word_cnt;
  logic                 trunc_flag;
  logic [NUM_BUF-1:0]   sel_oh;

  // First empty buffer at or after rr_ptr, wrapping modulo NUM_BUF.
  always_comb begin
    pick      = '0;
    any_empty = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_BUF))
        cand = cand - (IW+1)'(NUM_BUF);
      if (!any_empty && buf_empty[cand[IW-1:0]]) begin
        any_empty = 1'b1;
        pick      = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_BUF; i++)
      sel_oh[i] = (sel == IW'(i));
  end

  // Orphan words are drained in IDLE; the bop word waits until XFER.
  assign src_rdy = !reset && ((state == S_IDLE && src_wr && !src_bop) || state == S_XFER);
  assign buf_req = (state == S_REQ || state == S_XFER || state == S_FLUSH) ? sel_oh : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      sel           <= '0;
      rr_ptr        <= '0;
      word_cnt      <= '0;
      trunc_flag    <= 1'b0;
      buf_data      <= '0;
      buf_pkt_route <= '0;
      buf_wr        <= '0;
      pkt_count     <= '0;
      trunc_count   <= '0;
      err_count     <= '0;
    end else begin
      buf_wr <= '0;
      case (state)
        S_IDLE: begin
          if (src_wr && !src_bop) begin
            err_count <= err_count + 16'd1;
          end else if (src_wr && src_bop && any_empty) begin
            sel           <= pick;
            buf_pkt_route <= src_route;
            word_cnt      <= '0;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (buf_ack[sel])
            state <= S_XFER;
        end
        S_XFER: begin
          if (src_wr) begin
            buf_data <= src_data;
            if (word_cnt < 8'(MAX_WORDS)) begin
              buf_wr   <= sel_oh;
              word_cnt <= word_cnt + 8'd1;
            end else begin
              trunc_flag <= 1'b1;
            end
            if (src_eop)
              state <= S_FLUSH;
          end
        end
        S_FLUSH: state <= S_RELEASE;
        S_RELEASE: begin
          if (!buf_ack[sel]) begin
            pkt_count <= pkt_count + 32'd1;
            if (trunc_flag)
              trunc_count <= trunc_count + 16'd1;
            trunc_flag <= 1'b0;
            rr_ptr     <= (sel == IW'(NUM_BUF-1)) ? '0 : sel + 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/packet_dispatcher.md
# packet_dispatcher

- Sits directly upstream of the per-core packet buffers. It takes one 64-bit packet stream from the receive FIFO and assigns each packet to an empty buffer in round-robin order.
- It then writes the packet into that buffer over the buffer's req/ack/wr load handshake and latches the 24-bit route word for it.
- Only one packet is in flight at a time. The source is back-pressured until a buffer is granted.

## Interface
Parameters:
- NUM_BUF, 4, number of attached packet buffers (1..4).
- MAX_WORDS, 255, maximum words written per packet (1..255; buffer packet-length counter is 8 bits).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- src_data  in  64  packet word.
- src_route  in  24  route word; valid with the src_bop word.
- src_bop  in  1  first word of packet.
- src_eop  in  1  last word of packet.
- src_wr  in  1  word valid.
- src_rdy  out  1  word accepted when src_wr && src_rdy.
- buf_data  out  64  shared, registered write data to all buffers.
- buf_pkt_route  out  24  shared, registered route word for the current packet.
- buf_wr  out  NUM_BUF  one-hot, registered word write strobe.
- buf_req  out  NUM_BUF  one-hot load request.
- buf_ack  in  NUM_BUF  load acknowledge from each buffer.
- buf_empty  in  NUM_BUF  buffer idle and able to accept a packet.
- pkt_count  out  32  packets delivered.
- trunc_count  out  16  packets truncated at MAX_WORDS.
- err_count  out  16  orphan words discarded (word without bop while IDLE).

## Operation
States:
- IDLE: src_rdy = src_wr && !src_bop, so orphan words are discarded and err_count +1 per word.
  - If src_wr && src_bop and any buf_empty bit is set, choose sel = first empty index at or after rr_ptr (cyclic).
  - Latch src_route into buf_pkt_route, clear word_cnt, go to REQ.
  - The bop word itself is not yet accepted.
- REQ: buf_req[sel]=1, src_rdy=0. When buf_ack[sel]=1, go to XFER.
- XFER: buf_req[sel]=1, src_rdy=1.
  - Each accepted word is registered into buf_data; buf_wr[sel] pulses for one cycle if word_cnt < MAX_WORDS.
  - word_cnt increments (8-bit, saturating at MAX_WORDS).
  - Accepted words beyond MAX_WORDS are consumed, not written, and set trunc_flag.
  - When the src_eop word is accepted, go to FLUSH.
- FLUSH: one cycle. buf_req[sel]=1, src_rdy=0, and the final registered buf_wr is presented. Go to RELEASE.
- RELEASE: buf_req=0, src_rdy=0.
  - When buf_ack[sel]=0: pkt_count +1, trunc_count +1 if trunc_flag, clear trunc_flag.
  - Set rr_ptr = (sel+1) mod NUM_BUF and go to IDLE.

Other rules:
- A src_bop arriving in XFER is treated as ordinary data; the packet ends only on src_eop.
- buf_wr is 0 in every state except the cycle after a qualifying XFER acceptance.
- All counters wrap.

## Timing
- Reset: state IDLE, rr_ptr=0, sel=0.
- Outputs at reset: src_rdy=0 in the reset cycle, and buf_req, buf_wr, buf_data, buf_pkt_route, all counters = 0.
- Reset mid-packet:
  - buf_req drops the next cycle and the remaining source words are handled as orphans.
  - The buffer's partial packet is its own concern.
- Latency: bop word presented at cycle T in IDLE; REQ at T+1.
  - A buffer acking combinationally gives XFER at T+2: bop accepted at T+2, buf_wr at T+3.
- Back-to-back words give one buf_wr per cycle. buf_wr never asserts while buf_ack[sel]=0.
- eop accepted at cycle E: last buf_wr at E+1 (FLUSH); buf_req low from E+2; IDLE earliest E+3.
- No buffer empty: remain in IDLE with src_rdy=0 for the bop word, indefinitely.
- buf_empty is sampled only in IDLE. Loss of buf_empty after the grant is ignored; the dispatcher waits for ack.

## Test plan
- 4-word packet, all buffers empty, rr_ptr=0 → buf_req=0001, four buf_wr[0] pulses with matching data, buf_pkt_route = src_route, pkt_count=1, rr_ptr=1.
- Four 2-word packets back-to-back, all empty → buffers 0,1,2,3 granted in order; each buffer's eop buf_wr precedes its buf_req fall by one cycle.
- buf_empty=0101, rr_ptr=1 → buffer 2 chosen. Then buf_empty=0000 with bop pending → src_rdy stays 0 for 20 cycles; setting buf_empty[3]=1 → grant to buffer 3.
- 300-word packet, MAX_WORDS=255 → exactly 255 buf_wr pulses, all 300 words accepted, trunc_count=1, pkt_count=1.
- Three words without bop in IDLE, then a valid 1-word packet → err_count=3, one buf_wr, pkt_count=1.
- reset asserted after 2 of 5 words in XFER → next cycle buf_req=0, buf_wr=0, all counters=0; remaining 3 words counted as orphans (err_count=3).
